instr_decode: RTL and testbench
===============================

// Module: instr_decode
// PURPOSE
//   Decode stage that sits directly downstream of instruction fetch. It consumes the fetched
//   instruction and its PC, and holds the 32-entry integer register file. It produces the
//   rs1/rs2 operands, the sign-extended immediate and the decoded instruction fields for
//   execute. It also takes the write-back port. imm_o doubles as the byte offset that feeds
//   the fetch stage's PC-relative offset input on branches and jumps.
// PARAMETERS
//   XLEN      32            data/register width
//   NREG      32            number of architectural registers (x0..x31)
//   SP_RESET  32'h0000_7FFC reset value loaded into x2 (sp)
// PORTS
//   clk_i       in   1     single clock; all state updates on posedge
//   rst_n       in   1     synchronous, active-high reset (1 = reset)
//   instr_i     in   32    instruction from fetch (changes on negedge)
//   pc_i        in   32    PC of instr_i, from fetch
//   reg_write_i in   1     write-back enable
//   wb_rd_i     in   5     write-back destination register
//   wb_data_i   in   XLEN  write-back data
//   dbg_addr_i  in   5     debug read address
//   rs1_data_o  out  XLEN  register[instr_i[19:15]]
//   rs2_data_o  out  XLEN  register[instr_i[24:20]]
//   imm_o       out  32    sign-extended immediate (format from opcode)
//   rd_o        out  5     instr_i[11:7]
//   opcode_o    out  7     instr_i[6:0]
//   funct3_o    out  3     instr_i[14:12]
//   funct7_o    out  7     instr_i[31:25]
//   pc_o        out  32    pc_i passed through
//   illegal_o   out  1     1 = opcode not in supported set
//   dbg_data_o  out  XLEN  register[dbg_addr_i]
// BEHAVIOUR
//   - Register file: NREG x XLEN array. Reads are combinational (rs1, rs2 and dbg).
//     Writes happen on posedge clk_i when reg_write_i=1 and wb_rd_i!=0.
//   - Reset: on posedge with rst_n=1, all registers are cleared to 0 and x2 is loaded with
//     SP_RESET. Reset has priority over a simultaneous write. Reset asserted mid-operation
//     discards the pending write.
//   - After reset: rs1/rs2/dbg reads return 0, except reg 2, which returns SP_RESET.
//   - x0: reads are always 0, and writes to x0 are silently dropped (array entry unchanged).
//   - Write latency: the new value is visible on the read ports from the posedge of the write.
//     There is no bypass. A same-cycle read of wb_rd_i returns the old value.
//   - Field outputs (rd/opcode/funct3/funct7/pc_o) are pure combinational slices with no state.
//   - Immediate by opcode:
//       I-type (0010011, 0000011, 1100111, 1110011): {{20{i[31]}}, i[31:20]}
//       S-type (0100011):                            {{20{i[31]}}, i[31:25], i[11:7]}
//       B-type (1100011): {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}
//       J-type (1101111): {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
//       U-type (0110111, 0010111): {i[31:12], 12'b0}
//       R-type (0110011) and illegal: imm_o = 0
//   - illegal_o=1 for any opcode outside the 10 listed above (R/I/load/S/B/JAL/JALR/LUI/
//     AUIPC/SYSTEM). Register state is unaffected. Write-back is still obeyed, because
//     reg_write_i is owned by control.
//   - Bit widths: all immediates are exactly 32 bits. B/J offsets are even (bit0=0).
// TESTING
//   1. Assert rst_n 1 cycle -> dbg reads x0..x31 = 0, except x2 = 32'h0000_7FFC. Write x2
//      during reset -> still SP_RESET.
//   2. Write x5 = 32'hDEAD_BEEF with instr_i = 32'h0052_8033 (rs1=x5) -> rs1_data_o is old
//      value before posedge, 32'hDEAD_BEEF after.
//   3. Write x0 = 32'hFFFF_FFFF -> rs1/dbg for x0 read 0, and the next write to x1 is unaffected.
//   4. instr 32'hFFF0_0093 (addi x1,x0,-1) -> imm_o = 32'hFFFF_FFFF, rd_o=1, illegal_o=0.
//      instr 32'hFE00_0EE3 (beq, -4) -> imm_o = 32'hFFFF_FFFC.
//   5. instr 32'h0080_006F (jal +8) -> imm_o = 8. instr 32'h1234_5037 (lui) -> imm_o = 32'h1234_5000.
//   6. instr 32'h0000_007F -> illegal_o=1, imm_o=0. Sweep all 128 opcodes -> exactly 10 legal.

Source files
------------

// File: rtl/instr_decode.sv
// Decode stage: 32-entry integer register file with combinational read ports,
// one write-back port, immediate generation and instruction field slicing.
// The reset input is named rst_n for codebase consistency, but it is a
// synchronous, active-HIGH reset (rst_n = 1 resets the register file).
module instr_decode #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] SP_RESET = 32'h0000_7FFC
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [31:0]     instr_i,
  input  logic [31:0]     pc_i,
  input  logic            reg_write_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [31:0]     imm_o,
  output logic [4:0]      rd_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [31:0]     pc_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] dbg_data_o
);

  // Supported major opcodes.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U
  } imm_fmt_e;

  logic [XLEN-1:0] regs_q [NREG];
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  imm_fmt_e        imm_fmt;

  assign rs1_addr = instr_i[19:15];
  assign rs2_addr = instr_i[24:20];

  // Register file update: reset image wins over write-back; x0 is never written.
  // NOTE: the register file is deliberately reset here (x0..x31 cleared, sp
  // preloaded), so it maps to flops rather than a RAM macro; all state in this
  // block uses non-blocking assignments so every entry updates on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == 2) ? SP_RESET : '0;
      end
    end else if (reg_write_i && (wb_rd_i != 5'd0)) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  // Combinational read ports; x0 reads as zero regardless of the array contents.
  always_comb begin
    rs1_data_o = (rs1_addr   == 5'd0) ? '0 : regs_q[rs1_addr];
    rs2_data_o = (rs2_addr   == 5'd0) ? '0 : regs_q[rs2_addr];
    dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];
  end

  // Classify the opcode into an immediate format and flag unsupported opcodes.
  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    imm_fmt   = FMT_NONE;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm_fmt = FMT_I;
      OP_STORE:                            imm_fmt = FMT_S;
      OP_BRANCH:                           imm_fmt = FMT_B;
      OP_JAL:                              imm_fmt = FMT_J;
      OP_LUI, OP_AUIPC:                    imm_fmt = FMT_U;
      OP_REG:                              imm_fmt = FMT_NONE;
      default:                             illegal_o = 1'b1;
    endcase
  end

  // Assemble the sign-extended immediate for the selected format.
  always_comb begin
    imm_o = 32'd0;
    case (imm_fmt)
      FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      FMT_U: imm_o = {instr_i[31:12], 12'd0};
      default: imm_o = 32'd0;
    endcase
  end

  // Field outputs are plain slices of the fetched instruction.
  assign rd_o     = instr_i[11:7];
  assign opcode_o = instr_i[6:0];
  assign funct3_o = instr_i[14:12];
  assign funct7_o = instr_i[31:25];
  assign pc_o     = pc_i;

endmodule

// File: tb/tb_instr_decode.sv
// Directed testbench for instr_decode: reset image, write latency, x0 handling,
// immediate formats, field slicing, opcode legality sweep and back-to-back writes.
module tb_instr_decode;

  localparam logic [31:0] SP_RESET = 32'h0000_7FFC;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        reg_write_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] imm_o;
  logic [4:0]  rd_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] pc_o;
  logic        illegal_o;
  logic [31:0] dbg_data_o;

  int checks   = 0;
  int failures = 0;

  instr_decode #(
    .XLEN    (32),
    .NREG    (32),
    .SP_RESET(SP_RESET)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .reg_write_i(reg_write_i),
    .wb_rd_i    (wb_rd_i),
    .wb_data_i  (wb_data_i),
    .dbg_addr_i (dbg_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .imm_o      (imm_o),
    .rd_o       (rd_o),
    .opcode_o   (opcode_o),
    .funct3_o   (funct3_o),
    .funct7_o   (funct7_o),
    .pc_o       (pc_o),
    .illegal_o  (illegal_o),
    .dbg_data_o (dbg_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Reads register r through the debug port after letting combinational logic settle.
  task automatic dbg_read(input int r, output logic [31:0] val);
    dbg_addr_i = 5'(r);
    #1;
    val = dbg_data_o;
  endtask

  task automatic test_reset;
    logic [31:0] got;
    logic [31:0] exp;
    // Hold reset for one edge while a write to x2 is also requested.
    @(negedge clk_i);
    rst_n       = 1'b1;
    reg_write_i = 1'b1;
    wb_rd_i     = 5'd2;
    wb_data_i   = 32'h1234_5678;
    @(negedge clk_i);
    rst_n       = 1'b0;
    reg_write_i = 1'b0;
    for (int r = 0; r < 32; r++) begin
      dbg_read(r, got);
      exp = (r == 2) ? SP_RESET : 32'd0;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_x%0d: got %h expected %h", r, got, exp);
      end
    end
  endtask

  task automatic test_write_latency;
    // add x0, x5, x5: rs1 = rs2 = x5
    @(negedge clk_i);
    instr_i     = 32'h0052_8033;
    reg_write_i = 1'b1;
    wb_rd_i     = 5'd5;
    wb_data_i   = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (rs1_data_o !== 32'd0) begin
      failures++;
      $display("FAIL wr_latency_rs1_before: got %h expected %h", rs1_data_o, 32'd0);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (rs1_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wr_latency_rs1_after: got %h expected %h", rs1_data_o, 32'hDEAD_BEEF);
    end
    checks++;
    if (rs2_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wr_latency_rs2_after: got %h expected %h", rs2_data_o, 32'hDEAD_BEEF);
    end
    @(negedge clk_i);
    reg_write_i = 1'b0;
  endtask

  task automatic test_x0;
    logic [31:0] got;
    @(negedge clk_i);
    reg_write_i = 1'b1;
    wb_rd_i     = 5'd0;
    wb_data_i   = 32'hFFFF_FFFF;
    instr_i     = 32'h0000_0033;   // add x0, x0, x0: rs1 = rs2 = x0
    @(negedge clk_i);
    wb_rd_i     = 5'd1;
    wb_data_i   = 32'h0000_1111;
    checks++;
    if (rs1_data_o !== 32'd0) begin
      failures++;
      $display("FAIL x0_rs1: got %h expected %h", rs1_data_o, 32'd0);
    end
    dbg_read(0, got);
    checks++;
    if (got !== 32'd0) begin
      failures++;
      $display("FAIL x0_dbg: got %h expected %h", got, 32'd0);
    end
    @(negedge clk_i);
    reg_write_i = 1'b0;
    dbg_read(1, got);
    checks++;
    if (got !== 32'h0000_1111) begin
      failures++;
      $display("FAIL x1_after_x0_write: got %h expected %h", got, 32'h0000_1111);
    end
    dbg_read(5, got);
    checks++;
    if (got !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL x5_preserved: got %h expected %h", got, 32'hDEAD_BEEF);
    end
    dbg_read(0, got);
    checks++;
    if (got !== 32'd0) begin
      failures++;
      $display("FAIL x0_after_x1_write: got %h expected %h", got, 32'd0);
    end
  endtask

  task automatic test_immediates;
    logic [31:0] vec_instr [11];
    logic [31:0] vec_imm   [11];
    logic        vec_ill   [11];
    vec_instr[0]  = 32'hFFF0_0093; vec_imm[0]  = 32'hFFFF_FFFF; vec_ill[0]  = 1'b0; // addi x1,x0,-1
    vec_instr[1]  = 32'hFE00_0EE3; vec_imm[1]  = 32'hFFFF_FFFC; vec_ill[1]  = 1'b0; // beq -4
    vec_instr[2]  = 32'h0080_006F; vec_imm[2]  = 32'h0000_0008; vec_ill[2]  = 1'b0; // jal +8
    vec_instr[3]  = 32'h1234_5037; vec_imm[3]  = 32'h1234_5000; vec_ill[3]  = 1'b0; // lui
    vec_instr[4]  = 32'h0000_007F; vec_imm[4]  = 32'h0000_0000; vec_ill[4]  = 1'b1; // illegal
    vec_instr[5]  = 32'hFE51_2C23; vec_imm[5]  = 32'hFFFF_FFF8; vec_ill[5]  = 1'b0; // sw x5,-8(x2)
    vec_instr[6]  = 32'h0000_1097; vec_imm[6]  = 32'h0000_1000; vec_ill[6]  = 1'b0; // auipc x1,1
    vec_instr[7]  = 32'h0041_2083; vec_imm[7]  = 32'h0000_0004; vec_ill[7]  = 1'b0; // lw x1,4(x2)
    vec_instr[8]  = 32'h0052_8033; vec_imm[8]  = 32'h0000_0000; vec_ill[8]  = 1'b0; // add (R-type)
    vec_instr[9]  = 32'h0000_0463; vec_imm[9]  = 32'h0000_0008; vec_ill[9]  = 1'b0; // beq +8
    vec_instr[10] = 32'hFFF0_8067; vec_imm[10] = 32'hFFFF_FFFF; vec_ill[10] = 1'b0; // jalr x0,-1(x1)
    for (int k = 0; k < 11; k++) begin
      instr_i = vec_instr[k];
      #1;
      checks++;
      if (imm_o !== vec_imm[k]) begin
        failures++;
        $display("FAIL imm_vec%0d instr=%h: got %h expected %h", k, vec_instr[k], imm_o, vec_imm[k]);
      end
      checks++;
      if (illegal_o !== vec_ill[k]) begin
        failures++;
        $display("FAIL illegal_vec%0d instr=%h: got %b expected %b", k, vec_instr[k], illegal_o, vec_ill[k]);
      end
    end
  endtask

  task automatic test_fields;
    instr_i = 32'hFFF0_0093;   // addi x1, x0, -1
    pc_i    = 32'h0000_0100;
    #1;
    checks++;
    if (rd_o !== 5'd1) begin
      failures++;
      $display("FAIL addi_rd: got %0d expected %0d", rd_o, 1);
    end
    checks++;
    if (pc_o !== 32'h0000_0100) begin
      failures++;
      $display("FAIL pc_pass_a: got %h expected %h", pc_o, 32'h0000_0100);
    end
    instr_i = 32'hFE51_2C23;   // sw x5, -8(x2)
    pc_i    = 32'hCAFE_F00C;
    #1;
    checks++;
    if (rd_o !== 5'd24) begin
      failures++;
      $display("FAIL sw_rd: got %0d expected %0d", rd_o, 24);
    end
    checks++;
    if (opcode_o !== 7'h23) begin
      failures++;
      $display("FAIL sw_opcode: got %h expected %h", opcode_o, 7'h23);
    end
    checks++;
    if (funct3_o !== 3'b010) begin
      failures++;
      $display("FAIL sw_funct3: got %b expected %b", funct3_o, 3'b010);
    end
    checks++;
    if (funct7_o !== 7'h7F) begin
      failures++;
      $display("FAIL sw_funct7: got %h expected %h", funct7_o, 7'h7F);
    end
    checks++;
    if (pc_o !== 32'hCAFE_F00C) begin
      failures++;
      $display("FAIL pc_pass_b: got %h expected %h", pc_o, 32'hCAFE_F00C);
    end
    // rs1 = x2 (sp), rs2 = x5
    checks++;
    if (rs1_data_o !== SP_RESET) begin
      failures++;
      $display("FAIL sw_rs1_sp: got %h expected %h", rs1_data_o, SP_RESET);
    end
    checks++;
    if (rs2_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL sw_rs2_x5: got %h expected %h", rs2_data_o, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_opcode_sweep;
    int          legal_count;
    logic        exp_ill;
    logic [6:0]  op;
    legal_count = 0;
    for (int k = 0; k < 128; k++) begin
      op = 7'(k);
      instr_i = {25'd0, op};
      #1;
      case (op)
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
        7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011: exp_ill = 1'b0;
        default: exp_ill = 1'b1;
      endcase
      if (illegal_o === 1'b0) legal_count++;
      checks++;
      if (illegal_o !== exp_ill) begin
        failures++;
        $display("FAIL sweep_op_%b: got %b expected %b", op, illegal_o, exp_ill);
      end
    end
    checks++;
    if (legal_count != 10) begin
      failures++;
      $display("FAIL sweep_legal_count: got %0d expected %0d", legal_count, 10);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    logic [31:0] exp;
    // Illegal opcode on the instruction bus must not block write-back.
    instr_i = 32'h0000_007F;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      reg_write_i = 1'b1;
      wb_rd_i     = 5'(10 + k);
      wb_data_i   = 32'hA000_0000 + 32'(k * 32'h11);
    end
    @(negedge clk_i);
    reg_write_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dbg_read(10 + k, got);
      exp = 32'hA000_0000 + 32'(k * 32'h11);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_x%0d: got %h expected %h", 10 + k, got, exp);
      end
    end
  endtask

  task automatic test_reset_midop;
    logic [31:0] got;
    // Reset arrives together with a pending write to x7: write is discarded.
    @(negedge clk_i);
    rst_n       = 1'b1;
    reg_write_i = 1'b1;
    wb_rd_i     = 5'd7;
    wb_data_i   = 32'h5555_AAAA;
    @(negedge clk_i);
    rst_n       = 1'b0;
    reg_write_i = 1'b0;
    dbg_read(7, got);
    checks++;
    if (got !== 32'd0) begin
      failures++;
      $display("FAIL midreset_x7: got %h expected %h", got, 32'd0);
    end
    dbg_read(5, got);
    checks++;
    if (got !== 32'd0) begin
      failures++;
      $display("FAIL midreset_x5: got %h expected %h", got, 32'd0);
    end
    dbg_read(12, got);
    checks++;
    if (got !== 32'd0) begin
      failures++;
      $display("FAIL midreset_x12: got %h expected %h", got, 32'd0);
    end
    dbg_read(2, got);
    checks++;
    if (got !== SP_RESET) begin
      failures++;
      $display("FAIL midreset_x2: got %h expected %h", got, SP_RESET);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_i     = 32'd0;
    pc_i        = 32'd0;
    reg_write_i = 1'b0;
    wb_rd_i     = 5'd0;
    wb_data_i   = 32'd0;
    dbg_addr_i  = 5'd0;

    test_reset();
    test_write_latency();
    test_x0();
    test_immediates();
    test_fields();
    test_opcode_sweep();
    test_back_to_back();
    test_reset_midop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
